countdown_twodigit: RTL

- Two-digit BCD countdown alarm timer: loads a preset 00–99, decrements once per tick, asserts sp when the count reaches 00.
- Drives a two-digit multiplexed 7-segment display from the same o/com style segment interface used by the up-counting alarm.
- Sits between board switches/buttons (preset, start, stop, clear) and the display/speaker pins.

---
 rtl/countdown_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 27 ++
 rtl/countdown_twodigit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared constants and helpers for the two-digit BCD countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Digit enables are active-low: the zero bit marks the lit digit.
  localparam logic [1:0] COM_ONES = 2'b10;
  localparam logic [1:0] COM_TENS = 2'b01;

  // Segment patterns, bit order gfedcba, active-high.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1100111;

  // Clamp a switch-supplied digit into the legal BCD range.
  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    logic [3:0] r;
    if (d > BCD_MAX) begin
      r = BCD_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to gfedcba segment decoder; non-decimal codes show blank.
module seg7_decode
  import countdown_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Look up the segment pattern for the presented digit.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_twodigit.sv
// Two-digit BCD countdown alarm timer with multiplexed 7-segment output.
// All display outputs are computed from next-state values so that o, com
// and the count they depict always change on the same clock edge.
module countdown_twodigit
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 10000000,
  parameter int MUX_DIV  = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] set_ten,
  input  logic [3:0] set_one,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       sp,
  output logic [6:0] o,
  output logic [1:0] com
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MUX_W  = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [MUX_W-1:0]  MUX_LAST  = MUX_W'(MUX_DIV - 1);

  state_t            state_r, state_s;
  logic [3:0]        ten_r, ten_s;
  logic [3:0]        one_r, one_s;
  logic [TICK_W-1:0] tick_cnt_r, tick_cnt_s;
  logic [MUX_W-1:0]  mux_cnt_r, mux_cnt_s;
  logic              blink_r, blink_s;
  logic              sp_r, sp_s;
  logic [1:0]        com_r, com_s;
  logic [6:0]        o_r, o_s;
  logic              tick_s;
  logic              mux_wrap_s;
  logic [3:0]        digit_s;
  logic [6:0]        seg_s;

  // The divider only advances while counting down or blinking the alarm.
  assign tick_s = ((state_r == RUN) || (state_r == ALARM)) && (tick_cnt_r == TICK_LAST);

  // The alarm output rises one cycle after ALARM is entered and drops on exit.
  assign sp_s = (state_r == ALARM) && (state_s == ALARM);

  // Next state, count, tick divider and blink phase with load > clear > stop > start > tick.
  always_comb begin
    state_s = state_r;
    ten_s   = ten_r;
    one_s   = one_r;
    blink_s = blink_r;
    case (state_r)
      RUN, ALARM: tick_cnt_s = tick_s ? TICK_W'(0) : (tick_cnt_r + TICK_W'(1));
      PAUSE:      tick_cnt_s = tick_cnt_r;
      default:    tick_cnt_s = TICK_W'(0);
    endcase

    if (load) begin
      ten_s      = bcd_sat(set_ten);
      one_s      = bcd_sat(set_one);
      state_s    = IDLE;
      tick_cnt_s = TICK_W'(0);
      blink_s    = 1'b0;
    end else if (clear) begin
      ten_s      = 4'd0;
      one_s      = 4'd0;
      state_s    = IDLE;
      tick_cnt_s = TICK_W'(0);
      blink_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && ((ten_r != 4'd0) || (one_r != 4'd0))) begin
            state_s    = RUN;
            tick_cnt_s = TICK_W'(0);
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (stop) begin
            // Freeze the divider where it stands; resuming restarts it anyway.
            state_s    = PAUSE;
            tick_cnt_s = tick_cnt_r;
          end else if (tick_s) begin
            if (one_r != 4'd0) begin
              one_s = one_r - 4'd1;
            end else if (ten_r != 4'd0) begin
              one_s = BCD_MAX;
              ten_s = ten_r - 4'd1;
            end else begin
              one_s = one_r;
              ten_s = ten_r;
            end
            if ((ten_s == 4'd0) && (one_s == 4'd0)) begin
              state_s = ALARM;
              blink_s = 1'b0;
            end else begin
              state_s = RUN;
            end
          end else begin
            state_s = RUN;
          end
        end
        PAUSE: begin
          if (start) begin
            state_s    = RUN;
            tick_cnt_s = TICK_W'(0);
          end else begin
            state_s = PAUSE;
          end
        end
        ALARM: begin
          if (tick_s) begin
            blink_s = ~blink_r;
          end else begin
            blink_s = blink_r;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Free-running digit multiplexer; com alternates between the two digits.
  always_comb begin
    mux_wrap_s = (mux_cnt_r == MUX_LAST);
    if (mux_wrap_s) begin
      mux_cnt_s = MUX_W'(0);
      com_s     = (com_r == COM_ONES) ? COM_TENS : COM_ONES;
    end else begin
      mux_cnt_s = mux_cnt_r + MUX_W'(1);
      com_s     = com_r;
    end
  end

  assign digit_s = (com_s == COM_ONES) ? one_s : ten_s;

  seg7_decode u_seg7_decode (
    .digit (digit_s),
    .seg   (seg_s)
  );

  // Segment pattern for the digit about to be lit, with blanking and alarm blink.
  always_comb begin
    if (state_s == ALARM) begin
      o_s = blink_s ? SEG_BLANK : SEG_0;
    end else if ((com_s == COM_TENS) && (ten_s == 4'd0)) begin
      o_s = SEG_BLANK;
    end else begin
      o_s = seg_s;
    end
  end

  // Timer state, BCD count, tick divider and alarm output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ten_r      <= 4'd0;
      one_r      <= 4'd0;
      tick_cnt_r <= TICK_W'(0);
      blink_r    <= 1'b0;
      sp_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      ten_r      <= ten_s;
      one_r      <= one_s;
      tick_cnt_r <= tick_cnt_s;
      blink_r    <= blink_s;
      sp_r       <= sp_s;
    end
  end

  // Display multiplexer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_cnt_r <= MUX_W'(0);
      com_r     <= COM_ONES;
      o_r       <= SEG_0;
    end else begin
      mux_cnt_r <= mux_cnt_s;
      com_r     <= com_s;
      o_r       <= o_s;
    end
  end

  assign sp  = sp_r;
  assign com = com_r;
  assign o   = o_r;

endmodule
